// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x3 keypad matrix controller: FSM state type,
// matrix geometry, special key codes and the row/column to key-code map.
// No ports (package).
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam int ROW_W     = 4;
    localparam int COL_W     = 3;
    localparam int ROW_IDX_W = 2;
    localparam int CODE_W    = 4;

    localparam logic [CODE_W-1:0] KEY_STAR = 4'd10;
    localparam logic [CODE_W-1:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // True when exactly one column line is active.
    function automatic logic is_one_hot(input logic [COL_W-1:0] v);
        return (v != '0) && ((v & (v - 3'd1)) == '0);
    endfunction

    // Row index plus one-hot column to key code. Rows 0..2 give the digits
    // 1..9 in reading order; the bottom row is '*', '0', '#'.
    function automatic logic [CODE_W-1:0] key_map(input logic [ROW_IDX_W-1:0] row,
                                                  input logic [COL_W-1:0]     col_oh);
        logic [1:0]        c;
        logic [CODE_W-1:0] code;
        c = col_oh[2] ? 2'd2 : (col_oh[1] ? 2'd1 : 2'd0);
        if (row == 2'd3) begin
            case (c)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = (CODE_W'(row) * 4'd3) + CODE_W'(c) + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// ---------------------------------------------------------------------------
// keypad_col_sync
// Two-flop synchronizer for the raw keypad column lines, which are
// asynchronous to clk.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset, clears both flop stages
//   col_in - raw column lines
//   col_s  - synchronized column lines
// ---------------------------------------------------------------------------
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_s
);

    logic [COL_W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= '0;
            col_s <= '0;
        end else begin
            meta  <= col_in;
            col_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_matrix_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_matrix_ctrl
// Scans a 4-row x 3-column keypad, debounces presses and releases, and
// reports each accepted key once.
// Parameters:
//   SCAN_DIV     - clk cycles each row is driven (>= 4)
//   DEBOUNCE_CNT - consecutive matching dwell-end samples to accept a press
//                  or a release (>= 1)
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   col_in    - raw column lines, active-high, bit0 = left column
//   row_out   - one-hot active-high row drive, bit0 = top row
//   key_code  - code of the last accepted key
//   key_valid - one-cycle pulse with each newly accepted key_code
//   key_held  - high while the accepted key remains pressed
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotating row drive, looking for a single active column
// DEBOUNCE | row frozen, counting samples that repeat the captured column
// HELD     | key accepted, row frozen, waiting for an all-zero sample
// RELEASE  | row frozen, counting consecutive all-zero samples
// ---------------------------------------------------------------------------
module keypad_matrix_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [COL_W-1:0]  col_in,
    output logic [ROW_W-1:0]  row_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DB_W    = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]    DB_TARGET  = DB_W'(DEBOUNCE_CNT);
    localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);

    logic [COL_W-1:0]     col_s;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic                 dwell_end;

    kp_state_t            state, state_n;
    logic [ROW_IDX_W-1:0] row_idx, row_idx_n;
    logic [ROW_IDX_W-1:0] cap_row, cap_row_n;
    logic [COL_W-1:0]     cap_col, cap_col_n;
    logic [DB_W-1:0]      stable_cnt, stable_n;
    logic [DB_W-1:0]      release_cnt, release_n;
    logic [CODE_W-1:0]    key_code_n;
    logic                 key_valid_n;
    logic                 key_held_n;
    logic [DB_W-1:0]      stable_inc;
    logic [DB_W-1:0]      release_inc;

    keypad_col_sync u_col_sync (
        .clk    (clk),
        .rst    (rst),
        .col_in (col_in),
        .col_s  (col_s)
    );

    // Free-running dwell counter; every decision happens on its last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt <= '0;
        end else if (dwell_end) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
    end

    assign dwell_end = (dwell_cnt == DWELL_LAST);

    assign row_out = ROW_W'(1) << row_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SCAN;
            row_idx     <= '0;
            cap_row     <= '0;
            cap_col     <= '0;
            stable_cnt  <= '0;
            release_cnt <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            state       <= state_n;
            row_idx     <= row_idx_n;
            cap_row     <= cap_row_n;
            cap_col     <= cap_col_n;
            stable_cnt  <= stable_n;
            release_cnt <= release_n;
            key_code    <= key_code_n;
            key_valid   <= key_valid_n;
            key_held    <= key_held_n;
        end
    end

    assign stable_inc  = stable_cnt + DB_ONE;
    assign release_inc = release_cnt + DB_ONE;

    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        cap_row_n   = cap_row;
        cap_col_n   = cap_col;
        stable_n    = stable_cnt;
        release_n   = release_cnt;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;

        if (dwell_end) begin
            case (state)
                SCAN: begin
                    if (is_one_hot(col_s)) begin
                        cap_row_n = row_idx;
                        cap_col_n = col_s;
                        stable_n  = DB_ONE;
                        // A single-sample debounce accepts on the detecting sample.
                        if (DB_ONE == DB_TARGET) begin
                            key_code_n  = key_map(row_idx, col_s);
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                            state_n     = HELD;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                    end
                end

                DEBOUNCE: begin
                    if (col_s == cap_col) begin
                        stable_n = stable_inc;
                        if (stable_inc == DB_TARGET) begin
                            key_code_n  = key_map(cap_row, cap_col);
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                            state_n     = HELD;
                        end
                    end else begin
                        stable_n  = '0;
                        row_idx_n = row_idx + 2'd1;
                        state_n   = SCAN;
                    end
                end

                HELD: begin
                    if (col_s == '0) begin
                        release_n = DB_ONE;
                        if (DB_ONE == DB_TARGET) begin
                            key_held_n = 1'b0;
                            stable_n   = '0;
                            release_n  = '0;
                            row_idx_n  = row_idx + 2'd1;
                            state_n    = SCAN;
                        end else begin
                            state_n = RELEASE;
                        end
                    end
                end

                RELEASE: begin
                    if (col_s == '0) begin
                        release_n = release_inc;
                        if (release_inc == DB_TARGET) begin
                            key_held_n = 1'b0;
                            stable_n   = '0;
                            release_n  = '0;
                            row_idx_n  = row_idx + 2'd1;
                            state_n    = SCAN;
                        end
                    end else begin
                        // Bounce during release: the key is still considered held.
                        release_n = '0;
                        state_n   = HELD;
                    end
                end

                default: begin
                    state_n = SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_matrix_ctrl
// Directed self-checking bench for keypad_matrix_ctrl with SCAN_DIV=4,
// DEBOUNCE_CNT=3. A keypad model drives col_in from row_out; expected key
// codes are queued when a press is started and compared when key_valid fires.
// ---------------------------------------------------------------------------
module tb_keypad_matrix_ctrl;
    import keypad_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] col_in = 3'b000;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks = 0;
    int errors = 0;
    int tk = 0;
    int valid_cnt = 0;
    int last_valid_tk = -1;
    logic prev_valid = 1'b0;
    logic [3:0] exp_q[$];

    logic       model_en = 1'b1;
    logic [3:0] press_row = 4'b0000;
    logic [2:0] press_col = 3'b000;

    always #5 clk = ~clk;

    keypad_matrix_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs after the edge, score any key_valid pulse,
    // then drive the keypad model for the new row.
    task automatic tick();
        logic [3:0] e;
        @(posedge clk);
        #1;
        tk++;
        if (key_valid) begin
            check("valid_single_cycle", prev_valid, 0);
            valid_cnt++;
            last_valid_tk = tk;
            check("valid_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("key_code_on_valid", key_code, e);
            end
        end
        prev_valid = key_valid;
        if (model_en)
            col_in = (press_row != 4'b0000 && row_out == press_row) ? press_col : 3'b000;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_held(input logic v, input int budget, input string tag);
        int n;
        n = 0;
        while (key_held !== v && n < budget) begin
            tick();
            n++;
        end
        check(tag, key_held, v);
    endtask

    task automatic wait_row(input logic [3:0] r, input int budget, input string tag);
        int n;
        n = 0;
        while (row_out !== r && n < budget) begin
            tick();
            n++;
        end
        check(tag, row_out, r);
    endtask

    initial begin
        int vb;
        logic [3:0] prev_row;
        logic [3:0] exp_row;
        logic [2:0] r3_cols[3];
        logic [3:0] r3_codes[3];
        r3_cols  = '{3'b010, 3'b100, 3'b001};
        r3_codes = '{4'd0, KEY_HASH, KEY_STAR};

        // Reset values
        rst = 1'b0;
        col_in = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_out", row_out, 4'b0001);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_key_held", key_held, 0);
        rst = 1'b1;
        tk = 0;

        // Idle scan: row advances every 4 clocks
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("idle_row", row_out, 4'(1) << ((k / 4) % 4));
        end
        check("idle_no_valid", valid_cnt, 0);

        // Press '5' for 20 dwells
        vb = valid_cnt;
        exp_q.push_back(4'd5);
        press_row = 4'b0010;
        press_col = 3'b010;
        ticks(80);
        check("k5_valid_count", valid_cnt - vb, 1);
        check("k5_valid_time", last_valid_tk, 32);
        check("k5_key_code", key_code, 5);
        check("k5_key_held", key_held, 1);
        check("k5_row_frozen", row_out, 4'b0010);

        // Release exactly after a dwell-end edge (tk=96)
        press_row = 4'b0000;
        col_in = 3'b000;
        ticks(8);
        check("k5_held_after_2_zero", key_held, 1);
        check("k5_row_still_frozen", row_out, 4'b0010);
        ticks(4);
        check("k5_released", key_held, 0);
        check("k5_resume_row", row_out, 4'b0100);
        check("k5_code_kept", key_code, 5);

        // Bounce: one sample of col 001 in row 0001
        wait_row(4'b0001, 20, "bounce_reach_row0");
        vb = valid_cnt;
        model_en = 1'b0;
        col_in = 3'b001;
        ticks(4);
        check("bounce_row_frozen", row_out, 4'b0001);
        col_in = 3'b000;
        ticks(4);
        check("bounce_row_next", row_out, 4'b0010);
        check("bounce_no_valid", valid_cnt - vb, 0);
        check("bounce_code_kept", key_code, 5);
        check("bounce_not_held", key_held, 0);
        model_en = 1'b1;

        // Multi-key in row 1000: scanning never freezes
        vb = valid_cnt;
        press_row = 4'b1000;
        press_col = 3'b011;
        prev_row = row_out;
        for (int d = 0; d < 10; d++) begin
            ticks(4);
            exp_row = {prev_row[2:0], prev_row[3]};
            check("multikey_rotate", row_out, exp_row);
            prev_row = exp_row;
        end
        check("multikey_no_valid", valid_cnt - vb, 0);
        check("multikey_not_held", key_held, 0);
        press_row = 4'b0000;
        col_in = 3'b000;

        // Bottom-row codes
        for (int i = 0; i < 3; i++) begin
            vb = valid_cnt;
            exp_q.push_back(r3_codes[i]);
            press_row = 4'b1000;
            press_col = r3_cols[i];
            wait_held(1'b1, 80, "row3_held");
            check("row3_one_valid", valid_cnt - vb, 1);
            check("row3_key_code", key_code, r3_codes[i]);
            press_row = 4'b0000;
            col_in = 3'b000;
            wait_held(1'b0, 40, "row3_release");
        end

        // Press '9', then reset while held
        exp_q.push_back(4'd9);
        press_row = 4'b0100;
        press_col = 3'b100;
        wait_held(1'b1, 80, "k9_held");
        check("k9_key_code", key_code, 9);
        ticks(2);
        rst = 1'b0;
        #1;
        check("k9_rst_row_out", row_out, 4'b0001);
        check("k9_rst_key_held", key_held, 0);
        check("k9_rst_key_code", key_code, 0);
        check("k9_rst_key_valid", key_valid, 0);
        col_in = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("k9_rst_hold_code", key_code, 0);
        check("k9_rst_hold_row", row_out, 4'b0001);
        rst = 1'b1;
        tk = 0;
        prev_valid = 1'b0;

        // Key still pressed: one full debounce sequence after reset release
        vb = valid_cnt;
        exp_q.push_back(4'd9);
        wait_held(1'b1, 60, "k9_reheld");
        check("k9_re_valid_count", valid_cnt - vb, 1);
        check("k9_re_valid_time", last_valid_tk, 20);
        check("k9_re_key_code", key_code, 9);
        press_row = 4'b0000;
        col_in = 3'b000;
        wait_held(1'b0, 40, "k9_release");
        ticks(8);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_ctrl.md
KEYPAD_MATRIX_CTRL -- requirements
Module: keypad_matrix_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles each row is driven (dwell); SHALL be >= 4.
REQ-002 Parameter DEBOUNCE_CNT, default 4, consecutive matching dwell-end samples needed to accept a press or release; SHALL be >= 1.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 col_in  input  3  raw keypad column lines, active-high; bit0 is the left column, asynchronous to clk.
REQ-006 row_out  output  4  one-hot, active-high row drive; bit0 is the top row.
REQ-007 key_code  output  4  code of last accepted key, held until the next accept.
REQ-008 key_valid  output  1  one-cycle pulse marking a newly accepted key_code.
REQ-009 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 col_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-011 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; col_s SHALL be sampled only when the counter equals SCAN_DIV-1 (dwell-end sample).
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: at each dwell-end, row_out rotates 0001->0010->0100->1000->0001. If the sample has exactly one bit set, the block captures row and column, sets the stable count to 1, freezes row_out and enters DEBOUNCE. A zero sample or one with more than one bit set is ignored.
REQ-014 DEBOUNCE: row_out frozen. A dwell-end sample equal to the captured column increments the stable count. Any other sample returns to SCAN, with row_out advancing to the next row at that same edge.
REQ-015 When the stable count reaches DEBOUNCE_CNT, the block SHALL update key_code, assert key_valid for exactly the next clk cycle, set key_held=1 and enter HELD. With DEBOUNCE_CNT=1 this happens on the detecting sample itself.
REQ-016 Key code map, row r / column c: r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = 10(*),0,11(#).
REQ-017 HELD: row_out frozen. A zero dwell-end sample sets the release count to 1 and enters RELEASE. A non-zero sample of any value stays in HELD with no new pulse.
REQ-018 RELEASE: a zero sample increments the release count and a non-zero sample returns to HELD. On reaching DEBOUNCE_CNT the block SHALL clear key_held, enter SCAN and advance row_out at that edge.
REQ-019 Per press, key_valid SHALL pulse at most once. A continuously held key SHALL never re-trigger.
REQ-020 key_valid and key_held SHALL be registered outputs.

Reset
REQ-021 While rst=0, outputs SHALL be: row_out=0001, key_code=0, key_valid=0, key_held=0. Internal state: state=SCAN, dwell, stable and release counters =0, synchronizer flops =0.
REQ-022 Reset asserted in any state, including mid-DEBOUNCE or HELD, SHALL take effect immediately. No key_valid pulse SHALL be generated from a press begun before reset release until that press passes a full DEBOUNCE sequence.

Structure
REQ-023 Shared package keypad_pkg SHALL hold the FSM state typedef, key code constants (KEY_STAR=10, KEY_HASH=11) and the row/column widths.
REQ-024 The 2-flop column synchronizer SHALL be a separate sub-module keypad_col_sync (3 bits wide). The counters, FSM and code map stay in keypad_matrix_ctrl.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-025 Reset/idle: assert rst=0, then release with col_in=0 -> row_out=0001, key_valid=0, key_code=0; row_out steps 0001->0010->0100->1000->0001 every 4 clk.
REQ-026 Press '5': col_in=010 whenever row_out=0010, held for 20 dwells -> exactly one key_valid pulse, key_code=5, key_held=1. Release to 000 -> key_held=0 after the 3rd zero sample, then scanning resumes at row 0100.
REQ-027 Bounce: col_in=001 for one dwell-end sample in row 0001, then 000 -> no key_valid, key_code unchanged, row_out continues to 0010.
REQ-028 Multi-key: col_in=011 during row 1000 for 10 dwells -> no key_valid, scanning never freezes.
REQ-029 Row 3 codes: col_in=010 in row 1000 -> key_code=0; col_in=100 in row 1000 -> key_code=11; col_in=001 in row 1000 -> key_code=10.
REQ-030 Reset mid-HELD: press '9', wait for key_held=1, pulse rst=0 for 2 clk while the key stays pressed -> outputs return to reset values. After release of rst, exactly one new key_valid with key_code=9 follows the DEBOUNCE sequence.
